// File: rtl/alarm_controller.sv
// Alarm controller: holds the alarm time, detects the rising edge of the time
// match and runs the idle/armed/ringing/snooze state machine driving the buzzer.
module alarm_controller #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MAX   = 10,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] hour_i,
  input  logic [5:0] min_i,
  input  logic       min_tick_i,
  input  logic [4:0] al_in_hour_i,
  input  logic [5:0] al_in_min_i,
  input  logic       ld_al_i,
  input  logic       arm_i,
  input  logic       snooze_i,
  input  logic       stop_i,
  output logic       buzz_o,
  output logic [1:0] state_o,
  output logic [4:0] al_hour_o,
  output logic [5:0] al_min_o,
  output logic [3:0] snz_left_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_RING   = 2'b10,
    S_SNOOZE = 2'b11
  } state_e;

  localparam logic [3:0] SnoozeMinW = 4'(SNOOZE_MIN);
  localparam logic [3:0] RingMaxW   = 4'(RING_MAX);
  localparam logic [2:0] MaxSnoozeW = 3'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic [4:0] al_hour_q, al_hour_d;
  logic [5:0] al_min_q, al_min_d;
  logic [3:0] snz_left_q, snz_left_d;
  logic [3:0] ring_q, ring_d;
  logic [2:0] snz_cnt_q, snz_cnt_d;
  logic       match_prev_q;
  logic       buzz_q;
  logic       match;
  logic       trigger;

  assign match   = (hour_i == al_hour_q) && (min_i == al_min_q);
  assign trigger = match && !match_prev_q;

  // match_prev resets high so that a 00:00 clock right after reset does not ring.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      al_hour_q    <= '0;
      al_min_q     <= '0;
      snz_left_q   <= '0;
      ring_q       <= '0;
      snz_cnt_q    <= '0;
      match_prev_q <= 1'b1;
      buzz_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      al_hour_q    <= al_hour_d;
      al_min_q     <= al_min_d;
      snz_left_q   <= snz_left_d;
      ring_q       <= ring_d;
      snz_cnt_q    <= snz_cnt_d;
      match_prev_q <= match;
      buzz_q       <= (state_d == S_RING);
    end
  end

  always_comb begin
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    if (ld_al_i && (al_in_hour_i <= 5'd23) && (al_in_min_i <= 6'd59)) begin
      al_hour_d = al_in_hour_i;
      al_min_d  = al_in_min_i;
    end
  end

  // A SNOOZE refused for lack of remaining snoozes is treated as absent, so a
  // coincident MIN_TICK still advances the ring timer.
  always_comb begin
    state_d    = state_q;
    snz_left_d = snz_left_q;
    ring_d     = ring_q;
    snz_cnt_d  = snz_cnt_q;
    if (!arm_i) begin
      state_d    = S_IDLE;
      snz_left_d = '0;
      ring_d     = '0;
      snz_cnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          if (trigger) begin
            state_d   = S_RING;
            ring_d    = '0;
            snz_cnt_d = '0;
          end
        end
        S_RING: begin
          if (stop_i) begin
            state_d   = S_ARMED;
            ring_d    = '0;
            snz_cnt_d = '0;
          end else if (snooze_i && (snz_cnt_q < MaxSnoozeW)) begin
            state_d    = S_SNOOZE;
            snz_left_d = SnoozeMinW;
            snz_cnt_d  = snz_cnt_q + 3'd1;
          end else if (min_tick_i) begin
            if ((ring_q + 4'd1) == RingMaxW) begin
              state_d   = S_ARMED;
              ring_d    = '0;
              snz_cnt_d = '0;
            end else begin
              ring_d = ring_q + 4'd1;
            end
          end
        end
        S_SNOOZE: begin
          if (stop_i) begin
            state_d    = S_ARMED;
            snz_left_d = '0;
            snz_cnt_d  = '0;
          end else if (min_tick_i) begin
            if (snz_left_q == 4'd1) begin
              state_d    = S_RING;
              snz_left_d = '0;
              ring_d     = '0;
            end else begin
              snz_left_d = snz_left_q - 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign buzz_o     = buzz_q;
  assign state_o    = state_q;
  assign al_hour_o  = al_hour_q;
  assign al_min_o   = al_min_q;
  assign snz_left_o = snz_left_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: constant vector table, hand-written multi-cycle
// sequences, then random stimulus compared against an event-level model.
module tb_alarm_controller;

  localparam int SnoozeMin = 5;
  localparam int RingMax   = 10;
  localparam int MaxSnooze = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] hour = '0;
  logic [5:0] minute = '0;
  logic       minTick = 1'b0;
  logic [4:0] alInHour = '0;
  logic [5:0] alInMin = '0;
  logic       ldAl = 1'b0;
  logic       arm = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       buzz;
  logic [1:0] state;
  logic [4:0] alHour;
  logic [5:0] alMin;
  logic [3:0] snzLeft;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: plain integers, advanced once per clock edge.
  int  mState, mAlH, mAlM, mRingMin, mSnzLeft, mSnzUsed;
  bit  mPrevMatch;

  int  curArm, curHour, curMin;

  alarm_controller #(
    .SNOOZE_MIN(SnoozeMin),
    .RING_MAX  (RingMax),
    .MAX_SNOOZE(MaxSnooze)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .hour_i      (hour),
    .min_i       (minute),
    .min_tick_i  (minTick),
    .al_in_hour_i(alInHour),
    .al_in_min_i (alInMin),
    .ld_al_i     (ldAl),
    .arm_i       (arm),
    .snooze_i    (snooze),
    .stop_i      (stop),
    .buzz_o      (buzz),
    .state_o     (state),
    .al_hour_o   (alHour),
    .al_min_o    (alMin),
    .snz_left_o  (snzLeft)
  );

  always #5 clk = ~clk;

  typedef struct {
    int arm, ld, alh, alm, hr, mn, tick, snz, stp;
    int expState, expBuzz, expAlH, expAlM;
  } vec_t;

  task automatic modelReset();
    mState = 0; mAlH = 0; mAlM = 0; mRingMin = 0; mSnzLeft = 0; mSnzUsed = 0;
    mPrevMatch = 1'b1;
  endtask

  task automatic modelStep(input int a, input int ld, input int alh, input int alm,
                           input int hr, input int mn, input int tick, input int snz,
                           input int stp);
    bit isMatch;
    bit fire;
    isMatch = (hr == mAlH) && (mn == mAlM);
    fire = isMatch && !mPrevMatch;
    mPrevMatch = isMatch;
    if (ld != 0 && alh <= 23 && alm <= 59) begin
      mAlH = alh;
      mAlM = alm;
    end
    if (a == 0) begin
      mState = 0; mRingMin = 0; mSnzLeft = 0; mSnzUsed = 0;
    end else if (mState == 0) begin
      mState = 1;
    end else if (mState == 1) begin
      if (fire) begin mState = 2; mRingMin = 0; mSnzUsed = 0; end
    end else if (mState == 2) begin
      if (stp != 0) begin
        mState = 1; mSnzUsed = 0;
      end else if (snz != 0 && mSnzUsed < MaxSnooze) begin
        mState = 3; mSnzLeft = SnoozeMin; mSnzUsed++;
      end else if (tick != 0) begin
        mRingMin++;
        if (mRingMin >= RingMax) begin mState = 1; mSnzUsed = 0; end
      end
    end else begin
      if (stp != 0) begin
        mState = 1; mSnzLeft = 0; mSnzUsed = 0;
      end else if (tick != 0) begin
        mSnzLeft--;
        if (mSnzLeft == 0) begin mState = 2; mRingMin = 0; end
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int a, input int ld, input int alh, input int alm,
                               input int hr, input int mn, input int tick, input int snz,
                               input int stp);
    arm = a[0]; ldAl = ld[0]; alInHour = alh[4:0]; alInMin = alm[5:0];
    hour = hr[4:0]; minute = mn[5:0]; minTick = tick[0]; snooze = snz[0]; stop = stp[0];
    modelStep(a, ld, alh, alm, hr, mn, tick, snz, stp);
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input int tick, input int snz, input int stp);
    applyStimulus(curArm, 0, 0, 0, curHour, curMin, tick, snz, stp);
  endtask

  vec_t vecs[15];

  initial begin
    //                arm ld alh alm hr mn tk sz sp  st bz aH aM
    vecs[0]  = '{0, 1, 6, 30, 6, 28, 0, 0, 0, 0, 0, 6, 30};
    vecs[1]  = '{0, 1, 24, 10, 6, 28, 0, 0, 0, 0, 0, 6, 30};
    vecs[2]  = '{0, 1, 5, 60, 6, 28, 0, 0, 0, 0, 0, 6, 30};
    vecs[3]  = '{1, 0, 0, 0, 6, 29, 0, 0, 0, 1, 0, 6, 30};
    vecs[4]  = '{1, 0, 0, 0, 6, 30, 1, 0, 0, 2, 1, 6, 30};
    vecs[5]  = '{1, 0, 0, 0, 6, 30, 0, 0, 0, 2, 1, 6, 30};
    vecs[6]  = '{1, 0, 0, 0, 6, 30, 0, 0, 1, 1, 0, 6, 30};
    vecs[7]  = '{1, 0, 0, 0, 6, 30, 0, 0, 0, 1, 0, 6, 30};
    vecs[8]  = '{1, 0, 0, 0, 6, 31, 1, 0, 0, 1, 0, 6, 30};
    vecs[9]  = '{0, 0, 0, 0, 6, 30, 0, 0, 0, 0, 0, 6, 30};
    vecs[10] = '{1, 0, 0, 0, 6, 30, 0, 0, 0, 1, 0, 6, 30};
    vecs[11] = '{1, 0, 0, 0, 6, 30, 0, 0, 0, 1, 0, 6, 30};
    vecs[12] = '{1, 1, 7, 0, 6, 30, 0, 0, 0, 1, 0, 7, 0};
    vecs[13] = '{1, 0, 0, 0, 6, 59, 0, 0, 0, 1, 0, 7, 0};
    vecs[14] = '{1, 0, 0, 0, 7, 0, 1, 0, 0, 2, 1, 7, 0};

    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset state", state, 0);
    checkOutput("reset buzz", buzz, 0);
    checkOutput("reset alHour", alHour, 0);
    checkOutput("reset alMin", alMin, 0);
    checkOutput("reset snzLeft", snzLeft, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].arm, vecs[i].ld, vecs[i].alh, vecs[i].alm, vecs[i].hr,
                    vecs[i].mn, vecs[i].tick, vecs[i].snz, vecs[i].stp);
      checkOutput($sformatf("vec%0d state", i), state, vecs[i].expState);
      checkOutput($sformatf("vec%0d buzz", i), buzz, vecs[i].expBuzz);
      checkOutput($sformatf("vec%0d alHour", i), alHour, vecs[i].expAlH);
      checkOutput($sformatf("vec%0d alMin", i), alMin, vecs[i].expAlM);
    end

    // Snooze cycles until the allowance is spent; the next snooze is refused.
    curArm = 1; curHour = 7; curMin = 1;
    for (int k = 0; k < MaxSnooze; k++) begin
      ctl(0, 1, 0);
      checkOutput($sformatf("snooze%0d state", k), state, 3);
      checkOutput($sformatf("snooze%0d snzLeft", k), snzLeft, SnoozeMin);
      for (int t = 1; t <= SnoozeMin; t++) begin
        ctl(1, 0, 0);
        if (t < SnoozeMin) begin
          checkOutput($sformatf("snooze%0d tick%0d snzLeft", k, t), snzLeft, SnoozeMin - t);
        end else begin
          checkOutput($sformatf("snooze%0d expiry state", k), state, 2);
          checkOutput($sformatf("snooze%0d expiry snzLeft", k), snzLeft, 0);
        end
      end
    end
    ctl(0, 1, 0);
    checkOutput("extra snooze state", state, 2);
    checkOutput("extra snooze buzz", buzz, 1);

    // Unattended ringing auto-stops after RingMax ticks.
    for (int t = 1; t <= RingMax; t++) begin
      ctl(1, 0, 0);
      if (t == RingMax - 1) checkOutput("ring before timeout state", state, 2);
    end
    checkOutput("ring timeout state", state, 1);
    checkOutput("ring timeout buzz", buzz, 0);

    // New alarm at 08:00; snooze coincident with a tick wins.
    applyStimulus(1, 1, 8, 0, 7, 1, 0, 0, 0);
    checkOutput("load while armed state", state, 1);
    curHour = 8; curMin = 0;
    ctl(0, 0, 0);
    checkOutput("08:00 ring state", state, 2);
    ctl(1, 1, 0);
    checkOutput("snooze+tick state", state, 3);
    checkOutput("snooze+tick snzLeft", snzLeft, SnoozeMin);
    ctl(1, 0, 0);
    ctl(1, 0, 0);
    checkOutput("snooze two ticks snzLeft", snzLeft, 3);
    curArm = 0;
    ctl(0, 0, 0);
    checkOutput("disarm in snooze state", state, 0);
    checkOutput("disarm in snooze snzLeft", snzLeft, 0);

    // Asynchronous reset while ringing takes effect without a clock edge.
    curArm = 1;
    ctl(0, 0, 0);
    curMin = 1;
    ctl(0, 0, 0);
    curMin = 0;
    ctl(0, 0, 0);
    checkOutput("pre-reset ringing state", state, 2);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async reset state", state, 0);
    checkOutput("async reset buzz", buzz, 0);
    checkOutput("async reset alHour", alHour, 0);
    checkOutput("async reset alMin", alMin, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 400; c++) begin
      int a, ld, alh, alm, hr, mn;
      a  = ($urandom_range(0, 19) == 0) ? 0 : 1;
      ld = ($urandom_range(0, 15) == 0) ? 1 : 0;
      alh = $urandom_range(0, 25);
      alm = $urandom_range(0, 62);
      if ($urandom_range(0, 2) == 0) begin
        hr = mAlH; mn = mAlM;
      end else begin
        hr = $urandom_range(0, 23); mn = $urandom_range(0, 59);
      end
      applyStimulus(a, ld, alh, alm, hr, mn, ($urandom_range(0, 2) == 0) ? 1 : 0,
                    ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 15) == 0) ? 1 : 0);
      checkOutput($sformatf("rand%0d state", c), state, mState);
      checkOutput($sformatf("rand%0d buzz", c), buzz, (mState == 2) ? 1 : 0);
      checkOutput($sformatf("rand%0d snzLeft", c), snzLeft, mSnzLeft);
      checkOutput($sformatf("rand%0d alHour", c), alHour, mAlH);
      checkOutput($sformatf("rand%0d alMin", c), alMin, mAlM);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
